mem_bus_arbiter: RTL and testbench

- Round-robin arbiter sharing one single-port memory slave between two bus masters: m0 (instruction fetch) and m1 (data load/store).
- Sits between the core's two bus masters and the memory slave, so the dual-port memory can be replaced by a single-port macro.
- Forwards the granted master's request and routes the slave's response back to it.
- Includes a watchdog that force-completes stalled transfers and counts those events.

---
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one single-port memory slave
// between an instruction-fetch master (m0) and a data master (m1). The granted
// master's request is forwarded combinationally and the slave response is
// routed back to it. A watchdog force-completes transfers that stall too long
// and keeps a saturating count of those events.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_ss,
  input  logic          m0_ttype,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [1:0]    m0_tsize,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_bdone,
  input  logic          m1_ss,
  input  logic          m1_ttype,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [1:0]    m1_tsize,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_bdone,
  output logic          s_ss,
  output logic          s_ttype,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic [1:0]    s_tsize,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_bdone,
  output logic          timeout_err,
  output logic [7:0]    err_count
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [WW-1:0] wdog, wdog_nxt;
  logic [7:0]    err_nxt;

  logic          in_gnt;
  logic          gnt_ss;
  logic          complete;
  logic          timeout;
  logic [1:0]    pick;   // {valid, master index}

  // Round-robin choice: a lone requester wins, a tie goes to the master not served last.
  function automatic logic [1:0] arb(input logic r0, input logic r1, input logic lst);
    logic [1:0] res;
    if (r0 && r1) begin
      res = {1'b1, ~lst};
    end else if (r0) begin
      res = 2'b10;
    end else if (r1) begin
      res = 2'b11;
    end else begin
      res = 2'b00;
    end
    return res;
  endfunction

  // Transfer status of the current grant; while granted, last always names the
  // granted master, so arb() with last gives the post-completion choice directly.
  always_comb begin
    in_gnt   = (state == GNT0) || (state == GNT1);
    gnt_ss   = (state == GNT0) ? m0_ss : ((state == GNT1) ? m1_ss : 1'b0);
    complete = in_gnt & gnt_ss & s_bdone;
    timeout  = in_gnt & gnt_ss & ~s_bdone & (wdog == WDOG_MAX);
    pick     = arb(m0_ss, m1_ss, last);
  end

  // State, round-robin pointer, watchdog and error counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b0;
      wdog      <= '0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      wdog      <= wdog_nxt;
      err_count <= err_nxt;
    end
  end

  // Next-state logic: grant, back-to-back handover, timeout and abort.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    wdog_nxt  = wdog;
    err_nxt   = err_count;
    case (state)
      IDLE: begin
        if (pick[1]) begin
          state_nxt = pick[0] ? GNT1 : GNT0;
          last_nxt  = pick[0];
          wdog_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (complete) begin
          wdog_nxt = '0;
          if (pick[1]) begin
            state_nxt = pick[0] ? GNT1 : GNT0;
            last_nxt  = pick[0];
          end else begin
            state_nxt = IDLE;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
          wdog_nxt  = '0;
          if (err_count != 8'hFF) begin
            err_nxt = err_count + 8'd1;
          end else begin
            err_nxt = err_count;
          end
        end else if (!gnt_ss) begin
          state_nxt = IDLE;
          wdog_nxt  = '0;
        end else begin
          wdog_nxt = wdog + WW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        wdog_nxt  = '0;
      end
    endcase
  end

  // Output routing; a timeout suppresses s_ss so a stalled write cannot commit.
  always_comb begin
    s_ss        = 1'b0;
    s_ttype     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_tsize     = 2'd0;
    m0_rdata    = '0;
    m0_bdone    = 1'b0;
    m1_rdata    = '0;
    m1_bdone    = 1'b0;
    timeout_err = timeout;
    case (state)
      GNT0: begin
        s_ss     = m0_ss & ~timeout;
        s_ttype  = m0_ttype;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_tsize  = m0_tsize;
        m0_rdata = timeout ? '0 : s_rdata;
        m0_bdone = (s_bdone & m0_ss) | timeout;
      end
      GNT1: begin
        s_ss     = m1_ss & ~timeout;
        s_ttype  = m1_ttype;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_tsize  = m1_tsize;
        m1_rdata = timeout ? '0 : s_rdata;
        m1_bdone = (s_bdone & m1_ss) | timeout;
      end
      default: begin
        s_ss = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter with
// TIMEOUT=4. Inputs change 1 time unit after the rising edge and outputs are
// sampled in that same settled window.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_ss, m0_ttype, m1_ss, m1_ttype;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [1:0]    m0_tsize, m1_tsize;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_bdone, m1_bdone;
  logic          s_ss, s_ttype;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [1:0]    s_tsize;
  logic [DW-1:0] s_rdata;
  logic          s_bdone;
  logic          timeout_err;
  logic [7:0]    err_count;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_ss(m0_ss), .m0_ttype(m0_ttype), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_tsize(m0_tsize), .m0_rdata(m0_rdata), .m0_bdone(m0_bdone),
    .m1_ss(m1_ss), .m1_ttype(m1_ttype), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_tsize(m1_tsize), .m1_rdata(m1_rdata), .m1_bdone(m1_bdone),
    .s_ss(s_ss), .s_ttype(s_ttype), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_tsize(s_tsize), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .timeout_err(timeout_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_ss = 1'b0; m1_ss = 1'b0; s_bdone = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_ss = 1'b1; m0_ttype = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_tsize = 2'd2;
    m1_ss = 1'b1; m1_ttype = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_tsize = 2'd2;
    s_rdata = 32'h0; s_bdone = 1'b1;
    step();
    step();
    checks++; if (s_ss !== 1'b0) begin errors++; $display("FAIL reset_s_ss: got %b expected 0", s_ss); end
    checks++; if ({m0_bdone, m1_bdone} !== 2'b00) begin errors++; $display("FAIL reset_bdone: got %b expected 00", {m0_bdone, m1_bdone}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    m0_ss = 1'b0; m1_ss = 1'b0; s_bdone = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    m0_ss = 1'b1; m0_ttype = 1'b0; m0_addr = 32'h40; s_bdone = 1'b1; s_rdata = 32'hDEADBEEF;
    checks++; if (s_ss !== 1'b0) begin errors++; $display("FAIL read_arb_cycle_s_ss: got %b expected 0", s_ss); end
    step();
    checks++; if (s_ss !== 1'b1) begin errors++; $display("FAIL read_s_ss: got %b expected 1", s_ss); end
    checks++; if (s_addr !== 32'h40) begin errors++; $display("FAIL read_s_addr: got %h expected 00000040", s_addr); end
    checks++; if (m0_bdone !== 1'b1) begin errors++; $display("FAIL read_m0_bdone: got %b expected 1", m0_bdone); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m0_rdata: got %h expected deadbeef", m0_rdata); end
    checks++; if ({m1_bdone, m1_rdata} !== 33'd0) begin errors++; $display("FAIL read_m1_quiet: got %b/%h expected 0/0", m1_bdone, m1_rdata); end
    step();
    m0_ss = 1'b0;
    #1;
    checks++; if (m0_bdone !== 1'b0) begin errors++; $display("FAIL read_drop_bdone: got %b expected 0", m0_bdone); end
    idle_all();
  endtask

  task automatic test_tie();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_ss = 1'b1; m0_ttype = 1'b0; m0_addr = 32'h100;
    m1_ss = 1'b1; m1_ttype = 1'b0; m1_addr = 32'h200;
    s_bdone = 1'b1; s_rdata = 32'h5A5A0000;
    step();
    for (int i = 1; i <= 4; i++) begin
      logic [AW-1:0] exp_addr;
      logic [1:0]    exp_done;
      exp_addr = (i % 2 == 1) ? 32'h200 : 32'h100;
      exp_done = (i % 2 == 1) ? 2'b10 : 2'b01;
      checks++; if (s_addr !== exp_addr) begin errors++; $display("FAIL tie_addr_c%0d: got %h expected %h", i, s_addr, exp_addr); end
      checks++; if ({m1_bdone, m0_bdone} !== exp_done) begin errors++; $display("FAIL tie_bdone_c%0d: got %b expected %b", i, {m1_bdone, m0_bdone}, exp_done); end
      step();
    end
    idle_all();
  endtask

  task automatic test_slow_slave();
    m1_ss = 1'b1; m1_ttype = 1'b1; m1_addr = 32'h10; m1_wdata = 32'h12345678; m1_tsize = 2'd2;
    s_bdone = 1'b0;
    step();
    m0_ss = 1'b1; m0_ttype = 1'b0; m0_addr = 32'h80;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) s_bdone = 1'b1;
      #1;
      checks++; if ({s_ss, s_ttype, s_addr, s_wdata} !== {2'b11, 32'h10, 32'h12345678}) begin errors++; $display("FAIL slow_fwd_c%0d: got %b %b %h %h expected 1 1 00000010 12345678", i, s_ss, s_ttype, s_addr, s_wdata); end
      checks++; if (m1_bdone !== (i == 4)) begin errors++; $display("FAIL slow_m1_bdone_c%0d: got %b expected %b", i, m1_bdone, (i == 4)); end
      checks++; if ({m0_bdone, timeout_err} !== 2'b00) begin errors++; $display("FAIL slow_quiet_c%0d: got %b expected 00", i, {m0_bdone, timeout_err}); end
      step();
    end
    m1_ss = 1'b0;
    #1;
    checks++; if (s_addr !== 32'h80) begin errors++; $display("FAIL slow_handover_addr: got %h expected 00000080", s_addr); end
    checks++; if ({m0_bdone, m1_bdone} !== 2'b10) begin errors++; $display("FAIL slow_handover_bdone: got %b expected 10", {m0_bdone, m1_bdone}); end
    idle_all();
  endtask

  task automatic test_timeout();
    m0_ss = 1'b1; m0_ttype = 1'b0; m0_addr = 32'h300; s_bdone = 1'b0; s_rdata = 32'hAAAA5555;
    step();
    for (int i = 1; i <= 3; i++) begin
      checks++; if ({s_ss, m0_bdone, timeout_err} !== 3'b100) begin errors++; $display("FAIL to_wait_c%0d: got %b expected 100", i, {s_ss, m0_bdone, timeout_err}); end
      step();
    end
    checks++; if ({s_ss, m0_bdone, timeout_err} !== 3'b011) begin errors++; $display("FAIL to_fire: got %b expected 011", {s_ss, m0_bdone, timeout_err}); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 00000000", m0_rdata); end
    step();
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL to_err_count: got %0d expected 1", err_count); end
    checks++; if ({s_ss, timeout_err} !== 2'b00) begin errors++; $display("FAIL to_idle_next: got %b expected 00", {s_ss, timeout_err}); end
    for (int r = 0; r < 254; r++) begin
      repeat (5) step();
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL to_err_255: got %0d expected 255", err_count); end
    repeat (5) step();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL to_err_saturate: got %0d expected 255", err_count); end
    idle_all();
  endtask

  task automatic test_abort();
    m1_ss = 1'b1; m1_ttype = 1'b0; m1_addr = 32'h44; s_bdone = 1'b0;
    step();
    checks++; if (s_ss !== 1'b1) begin errors++; $display("FAIL abort_granted: got %b expected 1", s_ss); end
    m1_ss = 1'b0;
    #1;
    checks++; if (m1_bdone !== 1'b0) begin errors++; $display("FAIL abort_no_bdone: got %b expected 0", m1_bdone); end
    step();
    m1_ss = 1'b1;
    #1;
    checks++; if ({s_ss, m1_bdone, timeout_err} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b expected 000", {s_ss, m1_bdone, timeout_err}); end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL abort_err_count: got %0d expected 255", err_count); end
    step();
    checks++; if (s_ss !== 1'b1) begin errors++; $display("FAIL abort_regrant: got %b expected 1", s_ss); end
    idle_all();
  endtask

  task automatic test_reset_mid();
    m0_ss = 1'b1; m0_ttype = 1'b1; m0_addr = 32'h500; m0_wdata = 32'hCAFEF00D; s_bdone = 1'b0;
    step();
    checks++; if (s_ss !== 1'b1) begin errors++; $display("FAIL rstmid_granted: got %b expected 1", s_ss); end
    rst = 1'b1;
    m1_ss = 1'b1; m1_ttype = 1'b0; m1_addr = 32'h600;
    step();
    checks++; if ({s_ss, m0_bdone} !== 2'b00) begin errors++; $display("FAIL rstmid_dropped: got %b expected 00", {s_ss, m0_bdone}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rstmid_err_count: got %0d expected 0", err_count); end
    rst = 1'b0;
    step();
    s_bdone = 1'b1;
    #1;
    checks++; if ({s_ss, s_addr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL rstmid_m1_first: got %b %h expected 1 00000600", s_ss, s_addr); end
    checks++; if ({m1_bdone, m0_bdone} !== 2'b10) begin errors++; $display("FAIL rstmid_bdone: got %b expected 10", {m1_bdone, m0_bdone}); end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_slow_slave();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
